skid_reg: RTL and testbench



---
 rtl/skid_reg.sv | 104 ++++++++++
 tb/tb_skid_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/skid_reg.sv
// skid_reg: valid/ready pipeline stage with a two-entry skid buffer.
// Gives a bare data register a backpressure-capable interface at full
// throughput. in_rdy, out_vld and out_data all come straight from flops,
// so out_rdy has no combinational path to in_rdy.
module skid_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy
);

  // EMPTY: no entries; BUSY: head in main; FULL: head in main, next in skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   main_q,  main_d;
  logic [W-1:0]   skid_q,  skid_d;
  logic           in_rdy_q, in_rdy_d;
  logic           out_vld_q, out_vld_d;

  // Next-state and data-register load decisions
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (in_vld) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_vld && out_rdy) begin
          // head leaves and the new entry replaces it in the same cycle
          main_d = in_data;
        end else if (in_vld) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_rdy) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_rdy is low here, so nothing is accepted; only the skid entry
        // moves forward, which keeps strict FIFO order
        if (out_rdy) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // flush drops every buffered entry and any incoming one; data registers
    // keep their stale contents, masked by out_vld
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    // handshake flags are precomputed from the next state so they can be
    // registered alongside it
    in_rdy_d  = (state_d != FULL);
    out_vld_d = (state_d != EMPTY);
  end

  // State, payload and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_vld  = out_vld_q;
  assign out_data = main_q;

endmodule

// File: tb/tb_skid_reg.sv
// Bench for skid_reg (W=8): a queue model of the two-entry buffer checked
// every cycle, plus directed vectors with literal expectations.
module tb_skid_reg;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_vld;
  logic [7:0] in_data;
  logic       in_rdy;
  logic       out_vld;
  logic [7:0] out_data;
  logic       out_rdy;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  skid_reg #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_rdy  (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most two entries; the visible payload is
  // the most recent head (stale after it leaves or is flushed, 0 after reset)
  logic [7:0] mq[$];
  logic [7:0] shown = 8'h00;
  bit         acc = 1'b0;
  bit         hold_pending = 1'b0;
  logic [7:0] hold_val = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      shown = 8'h00;
      acc = 1'b0;
      hold_pending = 1'b0;
    end else begin
      bit in_x, out_x;
      in_x  = in_vld && (mq.size() < 2);
      out_x = out_rdy && (mq.size() > 0);
      hold_pending = out_vld && !out_rdy;
      hold_val = out_data;
      acc = in_x && !flush;
      if (flush) mq.delete();
      else begin
        if (out_x) void'(mq.pop_front());
        if (in_x) mq.push_back(in_data);
      end
      if (mq.size() > 0) shown = mq[0];
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    chk("no_x", 32'($isunknown({out_vld, in_rdy})), 32'd0);
    chk("out_vld", 32'(out_vld), 32'(mq.size() > 0));
    chk("in_rdy", 32'(in_rdy), 32'(mq.size() < 2));
    chk("out_data", 32'(out_data), 32'(shown));
    if (!in_rdy) chk("in_rdy_low_only_full", 32'(mq.size()), 32'd2);
    if (hold_pending) chk("stall_stable", 32'(out_data), 32'(hold_val));
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [7:0] payload;

  initial begin
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_data = 8'h00; out_rdy = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    cyc();

    // 1: asynchronous reset with FULL holding 0x11, 0x22
    in_vld = 1'b1; in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    chk("t1_full_rdy", 32'(in_rdy), 32'd0);
    chk("t1_full_head", 32'(out_data), 32'h11);
    in_vld = 1'b1; in_data = 8'h44;
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_vld", 32'(out_vld), 32'd0);
    chk("t1_rst_rdy", 32'(in_rdy), 32'd1);
    chk("t1_rst_data", 32'(out_data), 32'h00);
    cyc();
    chk("t1_rst_hold_data", 32'(out_data), 32'h00);
    rst = 1'b0; in_vld = 1'b1; in_data = 8'h33; cyc();
    chk("t1_first_data", 32'(out_data), 32'h33);
    chk("t1_first_vld", 32'(out_vld), 32'd1);

    // 2: streaming at one transfer per cycle
    out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_vld = 1'b1; in_data = 8'(i); cyc();
      chk("t2_stream_data", 32'(out_data), 32'(i));
      chk("t2_stream_rdy", 32'(in_rdy), 32'd1);
    end
    in_vld = 1'b0; cyc();
    chk("t2_drain", 32'(out_vld), 32'd0);

    // 3: backpressure fills the skid entry, then drains in order
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'hA0; cyc();
    in_data = 8'hA1; cyc();
    chk("t3_rdy_low", 32'(in_rdy), 32'd0);
    chk("t3_head", 32'(out_data), 32'hA0);
    in_data = 8'hA2; cyc();
    chk("t3_held_head", 32'(out_data), 32'hA0);
    out_rdy = 1'b1; cyc();
    chk("t3_second", 32'(out_data), 32'hA1);
    chk("t3_rdy_back", 32'(in_rdy), 32'd1);
    cyc();
    chk("t3_third", 32'(out_data), 32'hA2);
    in_vld = 1'b0; cyc();
    chk("t3_empty", 32'(out_vld), 32'd0);

    // 5: flush in FULL discards the incoming 0x55
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 8'h66; cyc();
    in_data = 8'h77; cyc();
    flush = 1'b1; out_rdy = 1'b1; in_data = 8'h55; cyc();
    chk("t5_vld", 32'(out_vld), 32'd0);
    chk("t5_rdy", 32'(in_rdy), 32'd1);
    flush = 1'b0; in_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_no_55", 32'(out_data == 8'h55), 32'd0);
    end

    // 6: EMPTY idle with out_rdy toggling
    for (int i = 0; i < 8; i++) begin
      out_rdy = ~out_rdy; cyc();
      chk("t6_vld", 32'(out_vld), 32'd0);
      chk("t6_data", 32'(out_data), 32'h66);
    end

    // 4: random stalls with an incrementing payload
    payload = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      if (acc) payload = payload + 8'd1;
      in_data = payload;
      in_vld  = 1'($urandom_range(0, 1));
      out_rdy = 1'($urandom_range(0, 1));
      cyc();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    cyc(); cyc();
    chk("t4_drained", 32'(out_vld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
